// File: rtl/control_seq_pkg.sv
// Shared opcodes, ALU select codes, phase numbers and sequencer types for the
// hardwired control unit of the 8-bit accumulator CPU.
package control_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_MOVAC = 4'h3;
    localparam logic [3:0] OP_MOVR  = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_JMPZ  = 4'h6;
    localparam logic [3:0] OP_JPNZ  = 4'h7;
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_INAC  = 4'hA;
    localparam logic [3:0] OP_CLAC  = 4'hB;
    localparam logic [3:0] OP_AND   = 4'hC;
    localparam logic [3:0] OP_OR    = 4'hD;
    localparam logic [3:0] OP_XOR   = 4'hE;
    localparam logic [3:0] OP_NOT   = 4'hF;
    localparam logic [4:0] OP_HALT  = 5'h10;

    localparam logic [3:0] ALUS_NONE = 4'd0;
    localparam logic [3:0] ALUS_ADD  = 4'd1;
    localparam logic [3:0] ALUS_SUB  = 4'd2;
    localparam logic [3:0] ALUS_AND  = 4'd3;
    localparam logic [3:0] ALUS_OR   = 4'd4;
    localparam logic [3:0] ALUS_XOR  = 4'd5;
    localparam logic [3:0] ALUS_INAC = 4'd6;
    localparam logic [3:0] ALUS_CLAC = 4'd7;
    localparam logic [3:0] ALUS_NOT  = 4'd8;
    localparam logic [3:0] ALUS_PASS = 4'd9;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;
    localparam logic [2:0] T7 = 3'd7;

    typedef enum logic [1:0] {ST_RUN, ST_STEPWAIT, ST_HALT} state_t;

    // Field order matches the top-level strobe port list.
    typedef struct packed {
        logic read;   logic write;  logic membus; logic busmem;
        logic arload; logic arinc;  logic pcload; logic pcinc;
        logic pcbus;  logic drload; logic drbus;  logic trload;
        logic trbus;  logic irload; logic rload;  logic rbus;
        logic zload;  logic acload; logic acbus;  logic drhbus;
        logic drlbus; logic clr;
    } strobes_t;

endpackage

// File: rtl/control_timing.sv
// Phase counter and run/step/halt state machine with memory stall tracking.
// rst is the combined active-low reset built by the top level.
module control_timing
    import control_seq_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       last_phase,
    input  logic       mem_access,
    input  logic       mem_ready,
    input  logic       step_mode,
    input  logic       step_req,
    input  logic       halt_req,
    output logic [2:0] tstate,
    output logic       adv,
    output logic       stall,
    output logic       timeout,
    output state_t     state
);

    localparam int WCNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    logic [WCNT_W-1:0] wait_cnt;
    logic              wait_hit;

    assign stall    = (state == ST_RUN) && mem_access && !mem_ready;
    assign adv      = (state == ST_RUN) && !stall && !halt_req;
    assign wait_hit = (WAIT_MAX > 0) && (wait_cnt == WCNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            tstate   <= T0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_HALT;
                    end else if (stall) begin
                        // The stall that would reach WAIT_MAX halts instead of counting on.
                        if (wait_hit) begin
                            timeout <= 1'b1;
                            state   <= ST_HALT;
                        end else begin
                            wait_cnt <= wait_cnt + WCNT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (last_phase) begin
                            tstate <= T0;
                            state  <= step_mode ? ST_STEPWAIT : ST_RUN;
                        end else begin
                            tstate <= tstate + 3'd1;
                        end
                    end
                end
                ST_STEPWAIT: begin
                    if (step_req) state <= ST_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_seq.sv
// Hardwired control unit: opcode decode, per-phase strobe generation with
// stall masking, sticky illegal flag and retired-instruction counter.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int OPC_W    = 8,
    parameter int ALUS_W   = 7,
    parameter int WAIT_MAX = 15,
    parameter int RET_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic [OPC_W-1:0]  din,
    input  logic              z,
    input  logic              mem_ready,
    input  logic              step_mode,
    input  logic              step_req,
    output logic              read,
    output logic              write,
    output logic              membus,
    output logic              busmem,
    output logic              arload,
    output logic              arinc,
    output logic              pcload,
    output logic              pcinc,
    output logic              pcbus,
    output logic              drload,
    output logic              drbus,
    output logic              trload,
    output logic              trbus,
    output logic              irload,
    output logic              rload,
    output logic              rbus,
    output logic              zload,
    output logic              acload,
    output logic              acbus,
    output logic              drhbus,
    output logic              drlbus,
    output logic              clr,
    output logic [ALUS_W-1:0] alus,
    output logic [2:0]        tstate,
    output logic              halted,
    output logic              illegal,
    output logic              mem_timeout,
    output logic [RET_W-1:0]  retired
);

    logic       rst_eff;
    logic       op_ok, is_halt, halt_req, jump_taken, is_branch;
    logic [3:0] op, raw_alus;
    logic       adv, stall;
    state_t     state;
    strobes_t   raw, strb;

    // Leaving RUN behaves exactly like the external reset.
    assign rst_eff = rst && (cpustate == 2'b11);

    assign op         = din[3:0];
    assign op_ok      = (din[OPC_W-1:4] == '0);
    assign is_halt    = (din == OPC_W'(OP_HALT));
    assign halt_req   = (state == ST_RUN) && (tstate == T3) && !op_ok;
    assign is_branch  = (op == OP_JMPZ) || (op == OP_JPNZ);
    assign jump_taken = (op == OP_JUMP) || ((op == OP_JMPZ) && z) || ((op == OP_JPNZ) && !z);

    always_comb begin
        raw      = '0;
        raw_alus = ALUS_NONE;
        case (tstate)
            T0: begin raw.pcbus = 1'b1; raw.arload = 1'b1; end
            T1: begin raw.read = 1'b1; raw.membus = 1'b1; raw.drload = 1'b1; raw.pcinc = 1'b1; end
            T2: begin raw.irload = 1'b1; raw.pcbus = 1'b1; raw.arload = 1'b1; end
            default: begin
                if (!op_ok) begin
                    raw = '0;
                end else if ((op == OP_LDAC) || (op == OP_STAC)) begin
                    case (tstate)
                        T3: begin raw.read = 1'b1; raw.membus = 1'b1; raw.drload = 1'b1; raw.pcinc = 1'b1; raw.arinc = 1'b1; end
                        T4: begin raw.read = 1'b1; raw.membus = 1'b1; raw.drload = 1'b1; raw.pcinc = 1'b1; raw.trload = 1'b1; end
                        T5: begin raw.drhbus = 1'b1; raw.trbus = 1'b1; raw.arload = 1'b1; end
                        T6: begin
                            raw.drload = 1'b1;
                            if (op == OP_LDAC) begin raw.read = 1'b1; raw.membus = 1'b1; end
                            else raw.acbus = 1'b1;
                        end
                        default: begin
                            raw.drlbus = 1'b1;
                            raw.clr    = 1'b1;
                            if (op == OP_LDAC) begin raw.acload = 1'b1; raw_alus = ALUS_PASS; end
                            else begin raw.busmem = 1'b1; raw.write = 1'b1; end
                        end
                    endcase
                end else if (jump_taken) begin
                    case (tstate)
                        T3: begin raw.read = 1'b1; raw.membus = 1'b1; raw.drload = 1'b1; raw.arinc = 1'b1; end
                        T4: begin raw.read = 1'b1; raw.membus = 1'b1; raw.drload = 1'b1; raw.trload = 1'b1; end
                        T5: begin raw.drhbus = 1'b1; raw.trbus = 1'b1; raw.pcload = 1'b1; raw.clr = 1'b1; end
                        default: ;
                    endcase
                end else if (is_branch) begin
                    // Untaken branch skips the two address bytes.
                    raw.pcinc = (tstate == T4) || (tstate == T5);
                    raw.clr   = (tstate == T5);
                end else if (tstate == T3) begin
                    raw.clr = 1'b1;
                    case (op)
                        OP_MOVAC: begin raw.acbus = 1'b1; raw.rload = 1'b1; end
                        OP_MOVR:  begin raw.rbus = 1'b1; raw.acload = 1'b1; raw_alus = ALUS_PASS; end
                        OP_ADD:   begin raw.rbus = 1'b1; raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_ADD; end
                        OP_SUB:   begin raw.rbus = 1'b1; raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_SUB; end
                        OP_AND:   begin raw.rbus = 1'b1; raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_AND; end
                        OP_OR:    begin raw.rbus = 1'b1; raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_OR; end
                        OP_XOR:   begin raw.rbus = 1'b1; raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_XOR; end
                        OP_INAC:  begin raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_INAC; end
                        OP_CLAC:  begin raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_CLAC; end
                        OP_NOT:   begin raw.acload = 1'b1; raw.zload = 1'b1; raw_alus = ALUS_NOT; end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // A stalled phase keeps only its memory handshake strobes.
    always_comb begin
        strb = '0;
        alus = '0;
        if (rst_eff && (state == ST_RUN)) begin
            if (stall) begin
                strb.read   = raw.read;
                strb.write  = raw.write;
                strb.membus = raw.membus;
                strb.busmem = raw.busmem;
                strb.drlbus = raw.drlbus;
            end else begin
                strb = raw;
                alus = ALUS_W'(raw_alus);
            end
        end
    end

    assign {read, write, membus, busmem, arload, arinc, pcload, pcinc,
            pcbus, drload, drbus, trload, trbus, irload, rload, rbus,
            zload, acload, acbus, drhbus, drlbus, clr} = strb;

    assign halted = (state == ST_HALT);

    control_timing #(
        .WAIT_MAX(WAIT_MAX)
    ) u_timing (
        .clk       (clk),
        .rst       (rst_eff),
        .last_phase(raw.clr),
        .mem_access(raw.read || raw.write),
        .mem_ready (mem_ready),
        .step_mode (step_mode),
        .step_req  (step_req),
        .halt_req  (halt_req),
        .tstate    (tstate),
        .adv       (adv),
        .stall     (stall),
        .timeout   (mem_timeout),
        .state     (state)
    );

    always_ff @(posedge clk or negedge rst_eff) begin
        if (!rst_eff) begin
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (adv && raw.clr) retired <= retired + RET_W'(1);
            if (halt_req && !is_halt) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: expected per-cycle outputs are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       rst, z, mem_ready, step_mode, step_req;
    logic [1:0] cpustate;
    logic [7:0] din;
    logic read, write, membus, busmem, arload, arinc, pcload, pcinc, pcbus, drload, drbus;
    logic trload, trbus, irload, rload, rbus, zload, acload, acbus, drhbus, drlbus, clr;
    logic [6:0]  alus;
    logic [2:0]  tstate;
    logic        halted, illegal, mem_timeout;
    logic [15:0] retired;
    logic [21:0] act;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [21:0] B_READ   = 22'd1 << 21;
    localparam logic [21:0] B_WRITE  = 22'd1 << 20;
    localparam logic [21:0] B_MEMBUS = 22'd1 << 19;
    localparam logic [21:0] B_BUSMEM = 22'd1 << 18;
    localparam logic [21:0] B_ARLOAD = 22'd1 << 17;
    localparam logic [21:0] B_ARINC  = 22'd1 << 16;
    localparam logic [21:0] B_PCLOAD = 22'd1 << 15;
    localparam logic [21:0] B_PCINC  = 22'd1 << 14;
    localparam logic [21:0] B_PCBUS  = 22'd1 << 13;
    localparam logic [21:0] B_DRLOAD = 22'd1 << 12;
    localparam logic [21:0] B_TRLOAD = 22'd1 << 10;
    localparam logic [21:0] B_TRBUS  = 22'd1 << 9;
    localparam logic [21:0] B_IRLOAD = 22'd1 << 8;
    localparam logic [21:0] B_RLOAD  = 22'd1 << 7;
    localparam logic [21:0] B_RBUS   = 22'd1 << 6;
    localparam logic [21:0] B_ZLOAD  = 22'd1 << 5;
    localparam logic [21:0] B_ACLOAD = 22'd1 << 4;
    localparam logic [21:0] B_ACBUS  = 22'd1 << 3;
    localparam logic [21:0] B_DRHBUS = 22'd1 << 2;
    localparam logic [21:0] B_DRLBUS = 22'd1 << 1;
    localparam logic [21:0] B_CLR    = 22'd1;

    localparam logic [21:0] ALU_R  = B_RBUS | B_ACLOAD | B_ZLOAD | B_CLR;
    localparam logic [21:0] ALU_A  = B_ACLOAD | B_ZLOAD | B_CLR;
    localparam logic [7:0]  T_OP   [11] = '{8'h08, 8'h00, 8'h03, 8'h04, 8'h09, 8'h0A,
                                            8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    localparam logic [21:0] T_STRB [11] = '{ALU_R, B_CLR, B_ACBUS | B_RLOAD | B_CLR,
                                            B_RBUS | B_ACLOAD | B_CLR, ALU_R, ALU_A,
                                            ALU_A, ALU_R, ALU_R, ALU_R, ALU_A};
    localparam logic [6:0]  T_ALUS [11] = '{7'd1, 7'd0, 7'd0, 7'd9, 7'd2, 7'd6,
                                            7'd7, 7'd3, 7'd4, 7'd5, 7'd8};

    typedef struct {
        string       tag;
        logic [21:0] strb;
        logic [2:0]  ts;
        logic [6:0]  al;
        logic        h, il, tmo;
        logic [15:0] ret;
    } exp_t;

    exp_t        q[$];
    logic [15:0] e_ret;
    logic        e_h, e_il, e_tmo;

    control_seq #(.OPC_W(8), .ALUS_W(7), .WAIT_MAX(4), .RET_W(16)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .din(din), .z(z),
        .mem_ready(mem_ready), .step_mode(step_mode), .step_req(step_req),
        .read(read), .write(write), .membus(membus), .busmem(busmem),
        .arload(arload), .arinc(arinc), .pcload(pcload), .pcinc(pcinc),
        .pcbus(pcbus), .drload(drload), .drbus(drbus), .trload(trload),
        .trbus(trbus), .irload(irload), .rload(rload), .rbus(rbus),
        .zload(zload), .acload(acload), .acbus(acbus), .drhbus(drhbus),
        .drlbus(drlbus), .clr(clr), .alus(alus), .tstate(tstate),
        .halted(halted), .illegal(illegal), .mem_timeout(mem_timeout),
        .retired(retired)
    );

    assign act = {read, write, membus, busmem, arload, arinc, pcload, pcinc,
                  pcbus, drload, drbus, trload, trbus, irload, rload, rbus,
                  zload, acload, acbus, drhbus, drlbus, clr};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic exp(input string tag, input logic [21:0] strb, input logic [2:0] ts,
                       input logic [6:0] al);
        exp_t e;
        e.tag = tag; e.strb = strb; e.ts = ts; e.al = al;
        e.h = e_h; e.il = e_il; e.tmo = e_tmo; e.ret = e_ret;
        q.push_back(e);
        #2;
        e = q.pop_front();
        chk({e.tag, ".strobes"}, 32'(act), 32'(e.strb));
        chk({e.tag, ".tstate"}, 32'(tstate), 32'(e.ts));
        chk({e.tag, ".alus"}, 32'(alus), 32'(e.al));
        chk({e.tag, ".halted"}, 32'(halted), 32'(e.h));
        chk({e.tag, ".illegal"}, 32'(illegal), 32'(e.il));
        chk({e.tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.tmo));
        chk({e.tag, ".retired"}, 32'(retired), 32'(e.ret));
        if (strb[0]) e_ret = e_ret + 16'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        exp({tag, "_t0"}, B_PCBUS | B_ARLOAD, 3'd0, 7'd0);
        exp({tag, "_t1"}, B_READ | B_MEMBUS | B_DRLOAD | B_PCINC, 3'd1, 7'd0);
        exp({tag, "_t2"}, B_IRLOAD | B_PCBUS | B_ARLOAD, 3'd2, 7'd0);
    endtask

    task automatic addr_phases(input string tag);
        exp({tag, "_t3"}, B_READ | B_MEMBUS | B_DRLOAD | B_PCINC | B_ARINC, 3'd3, 7'd0);
        exp({tag, "_t4"}, B_READ | B_MEMBUS | B_DRLOAD | B_PCINC | B_TRLOAD, 3'd4, 7'd0);
        exp({tag, "_t5"}, B_DRHBUS | B_TRBUS | B_ARLOAD, 3'd5, 7'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        e_ret = '0; e_h = 1'b0; e_il = 1'b0; e_tmo = 1'b0;
        exp(tag, '0, 3'd0, 7'd0);
        rst = 1'b1;
    endtask

    task automatic halt_case(input logic [7:0] opc, input logic ill, input string tag);
        din = opc;
        fetch(tag);
        exp({tag, "_t3"}, '0, 3'd3, 7'd0);
        e_h = 1'b1; e_il = ill;
        for (int i = 0; i < 20; i++) exp({tag, "_held"}, '0, 3'd3, 7'd0);
        do_reset({tag, "_rst"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish within 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; cpustate = 2'b11; din = '0; z = 1'b0;
        mem_ready = 1'b1; step_mode = 1'b0; step_req = 1'b0;
        e_ret = '0; e_h = 1'b0; e_il = 1'b0; e_tmo = 1'b0;
        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < 11; i++) begin
            din = T_OP[i];
            fetch($sformatf("op%0h", T_OP[i]));
            exp($sformatf("op%0h_t3", T_OP[i]), T_STRB[i], 3'd3, T_ALUS[i]);
        end

        din = 8'h01;
        exp("ldac_t0", B_PCBUS | B_ARLOAD, 3'd0, 7'd0);
        mem_ready = 1'b0;
        repeat (3) exp("ldac_stall", B_READ | B_MEMBUS, 3'd1, 7'd0);
        mem_ready = 1'b1;
        exp("ldac_t1", B_READ | B_MEMBUS | B_DRLOAD | B_PCINC, 3'd1, 7'd0);
        exp("ldac_t2", B_IRLOAD | B_PCBUS | B_ARLOAD, 3'd2, 7'd0);
        addr_phases("ldac");
        exp("ldac_t6", B_READ | B_MEMBUS | B_DRLOAD, 3'd6, 7'd0);
        exp("ldac_t7", B_DRLBUS | B_ACLOAD | B_CLR, 3'd7, 7'd9);

        din = 8'h02;
        fetch("stac");
        addr_phases("stac");
        exp("stac_t6", B_ACBUS | B_DRLOAD, 3'd6, 7'd0);
        mem_ready = 1'b0;
        exp("stac_stall", B_DRLBUS | B_BUSMEM | B_WRITE, 3'd7, 7'd0);
        mem_ready = 1'b1;
        exp("stac_t7", B_DRLBUS | B_BUSMEM | B_WRITE | B_CLR, 3'd7, 7'd0);

        din = 8'h06; z = 1'b0;
        fetch("jmpz_nt");
        exp("jmpz_nt_t3", '0, 3'd3, 7'd0);
        exp("jmpz_nt_t4", B_PCINC, 3'd4, 7'd0);
        exp("jmpz_nt_t5", B_PCINC | B_CLR, 3'd5, 7'd0);
        z = 1'b1;
        fetch("jmpz_tk");
        exp("jmpz_tk_t3", B_READ | B_MEMBUS | B_DRLOAD | B_ARINC, 3'd3, 7'd0);
        exp("jmpz_tk_t4", B_READ | B_MEMBUS | B_DRLOAD | B_TRLOAD, 3'd4, 7'd0);
        exp("jmpz_tk_t5", B_DRHBUS | B_TRBUS | B_PCLOAD | B_CLR, 3'd5, 7'd0);
        din = 8'h07;
        fetch("jpnz_nt");
        exp("jpnz_nt_t3", '0, 3'd3, 7'd0);
        exp("jpnz_nt_t4", B_PCINC, 3'd4, 7'd0);
        exp("jpnz_nt_t5", B_PCINC | B_CLR, 3'd5, 7'd0);

        din = 8'h01;
        fetch("abort");
        exp("abort_t3", B_READ | B_MEMBUS | B_DRLOAD | B_PCINC | B_ARINC, 3'd3, 7'd0);
        cpustate = 2'b01;
        e_ret = '0;
        exp("abort_out", '0, 3'd0, 7'd0);
        cpustate = 2'b11;
        din = 8'h03;
        fetch("after_abort");
        exp("after_abort_t3", B_ACBUS | B_RLOAD | B_CLR, 3'd3, 7'd0);

        step_mode = 1'b1; din = 8'h00;
        fetch("step1");
        exp("step1_t3", B_CLR, 3'd3, 7'd0);
        repeat (3) exp("stepwait1", '0, 3'd0, 7'd0);
        step_req = 1'b1;
        exp("step_req1", '0, 3'd0, 7'd0);
        step_req = 1'b0;
        fetch("step2");
        exp("step2_t3", B_CLR, 3'd3, 7'd0);
        repeat (2) exp("stepwait2", '0, 3'd0, 7'd0);
        step_mode = 1'b0; step_req = 1'b1;
        exp("step_req2", '0, 3'd0, 7'd0);
        step_req = 1'b0;
        fetch("step3");
        exp("step3_t3", B_CLR, 3'd3, 7'd0);

        halt_case(8'h10, 1'b0, "halt");
        halt_case(8'h25, 1'b1, "ill25");
        halt_case(8'h11, 1'b1, "ill11");

        din = 8'h08;
        exp("tmo_t0", B_PCBUS | B_ARLOAD, 3'd0, 7'd0);
        mem_ready = 1'b0;
        repeat (4) exp("tmo_stall", B_READ | B_MEMBUS, 3'd1, 7'd0);
        e_h = 1'b1; e_tmo = 1'b1;
        repeat (3) exp("tmo_halt", '0, 3'd1, 7'd0);
        mem_ready = 1'b1;
        exp("tmo_halt_rdy", '0, 3'd1, 7'd0);
        do_reset("tmo_rst");
        exp("post_rst_t0", B_PCBUS | B_ARLOAD, 3'd0, 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
